// File: rtl/tpu_pkg.sv
// Shared constants and types for the MMU loader/feeder pair.
package tpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE
  } loader_state_t;

  typedef enum logic {
    FRAME_FULL,
    FRAME_INPUT
  } frame_mode_t;

  localparam int N_ELEM            = 4;
  localparam int FULL_FRAME_BYTES  = 8;
  localparam int INPUT_FRAME_BYTES = 4;
  localparam int LAST_CC           = 5;

endpackage

// File: rtl/mmu_loader_if.sv
// Host byte-stream bundle feeding the MMU loader.
interface mmu_loader_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              reuse_weights;
  logic              abort;

  modport master (
    output in_valid, in_data, reuse_weights, abort,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_data, reuse_weights, abort,
    output in_ready
  );
endinterface

// File: rtl/mmu_loader.sv
// Captures a 2x2 weight and 2x2 input matrix from a host byte stream, then
// drives the feeder through one compute pass while holding the operands.
module mmu_loader #(
  parameter int DATA_W  = 8,
  parameter int LAST_CC = tpu_pkg::LAST_CC,
  parameter int CC_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  mmu_loader_if.slave       host,
  output logic [DATA_W-1:0] weights [0:3],
  output logic [DATA_W-1:0] inputs  [0:3],
  output logic              en,
  output logic [CC_W-1:0]   compute_cycles,
  output logic              weights_valid,
  output logic              busy
);
  import tpu_pkg::*;

  localparam int CNT_W = $clog2(FULL_FRAME_BYTES);

  loader_state_t    state;
  frame_mode_t      mode;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             input_only;
  logic             last_byte;
  logic [1:0]       idx;

  assign host.in_ready = (state != COMPUTE) && !rst;
  assign accept        = host.in_valid && host.in_ready;
  assign input_only    = host.reuse_weights && weights_valid;
  assign idx           = count[1:0];
  assign last_byte     = (mode == FRAME_INPUT) ? (count == CNT_W'(INPUT_FRAME_BYTES - 1))
                                               : (count == CNT_W'(FULL_FRAME_BYTES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      mode           <= FRAME_FULL;
      count          <= '0;
      weights_valid  <= 1'b0;
      en             <= 1'b0;
      compute_cycles <= '0;
      busy           <= 1'b0;
      for (int unsigned i = 0; i < N_ELEM; i++) begin
        weights[i] <= '0;
        inputs[i]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          // abort in IDLE swallows a coincident byte
          if (accept && !host.abort) begin
            count <= CNT_W'(1);
            state <= LOAD;
            busy  <= 1'b1;
            if (input_only) begin
              mode      <= FRAME_INPUT;
              inputs[0] <= host.in_data;
            end else begin
              mode          <= FRAME_FULL;
              weights[0]    <= host.in_data;
              weights_valid <= 1'b0;
            end
          end
        end

        LOAD: begin
          if (host.abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            count <= '0;
            if (mode == FRAME_FULL && count < CNT_W'(N_ELEM))
              weights_valid <= 1'b0;
          end else if (accept) begin
            if (mode == FRAME_INPUT) begin
              inputs[idx] <= host.in_data;
            end else if (count < CNT_W'(N_ELEM)) begin
              weights[idx] <= host.in_data;
              if (count == CNT_W'(N_ELEM - 1))
                weights_valid <= 1'b1;
            end else begin
              inputs[idx] <= host.in_data;
            end

            if (last_byte) begin
              count          <= '0;
              state          <= COMPUTE;
              en             <= 1'b1;
              compute_cycles <= '0;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end

        COMPUTE: begin
          if (host.abort || compute_cycles == CC_W'(LAST_CC)) begin
            state          <= IDLE;
            busy           <= 1'b0;
            en             <= 1'b0;
            compute_cycles <= '0;
          end else begin
            compute_cycles <= compute_cycles + CC_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          en    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_loader.sv
// Directed bench for mmu_loader with an operand scoreboard checked at pass start.
module tb_mmu_loader;

  localparam int DATA_W  = 8;
  localparam int LAST_CC = 5;
  localparam int CC_W    = 3;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] weights [0:3];
  logic [DATA_W-1:0] inputs  [0:3];
  logic              en;
  logic [CC_W-1:0]   compute_cycles;
  logic              weights_valid;
  logic              busy;

  mmu_loader_if #(.DATA_W(DATA_W)) hif ();

  mmu_loader #(
    .DATA_W (DATA_W),
    .LAST_CC(LAST_CC),
    .CC_W   (CC_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .host          (hif.slave),
    .weights       (weights),
    .inputs        (inputs),
    .en            (en),
    .compute_cycles(compute_cycles),
    .weights_valid (weights_valid),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [64:0] exp_q [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] operands();
    return {weights_valid, weights[0], weights[1], weights[2], weights[3],
            inputs[0], inputs[1], inputs[2], inputs[3]};
  endfunction

  // Sends n consecutive byte values starting at first; optionally leaves
  // in_valid asserted with 0xAA afterwards.
  task automatic send(input logic [7:0] first, input int unsigned n,
                      input logic reuse, input logic hold);
    for (int unsigned i = 0; i < n; i++) begin
      hif.in_valid      = 1'b1;
      hif.in_data       = first + 8'(i);
      hif.reuse_weights = reuse;
      step();
    end
    hif.reuse_weights = 1'b0;
    if (hold) begin
      hif.in_valid = 1'b1;
      hif.in_data  = 8'hAA;
    end else begin
      hif.in_valid = 1'b0;
    end
  endtask

  // Entered one cycle after the last byte edge; leaves in the first IDLE cycle.
  task automatic check_pass(input string tag);
    logic [64:0] exp, snap;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 65'(exp_q.size()), 65'd1);
    end else begin
      exp = exp_q.pop_front();
      chk({tag, "_operands"}, operands(), exp);
    end
    snap = operands();
    for (int unsigned k = 0; k <= LAST_CC; k++) begin
      chk({tag, "_en"}, 65'(en), 65'd1);
      chk({tag, "_cc"}, 65'(compute_cycles), 65'(k));
      chk({tag, "_ready_lo"}, 65'(hif.in_ready), 65'd0);
      chk({tag, "_busy"}, 65'(busy), 65'd1);
      chk({tag, "_frozen"}, operands(), snap);
      step();
    end
    chk({tag, "_en_off"}, 65'(en), 65'd0);
    chk({tag, "_cc_off"}, 65'(compute_cycles), 65'd0);
    chk({tag, "_ready_hi"}, 65'(hif.in_ready), 65'd1);
    chk({tag, "_idle"}, 65'(busy), 65'd0);
  endtask

  initial begin
    rst               = 1'b1;
    hif.in_valid      = 1'b0;
    hif.in_data       = '0;
    hif.reuse_weights = 1'b0;
    hif.abort         = 1'b0;
    step();
    step();
    chk("rst_ready", 65'(hif.in_ready), 65'd0);
    rst = 1'b0;
    #1;
    chk("rst_ready_after", 65'(hif.in_ready), 65'd1);
    chk("rst_operands", operands(), 65'd0);
    chk("rst_en", 65'(en), 65'd0);
    chk("rst_cc", 65'(compute_cycles), 65'd0);
    chk("rst_busy", 65'(busy), 65'd0);

    // Full frame 1..8
    exp_q.push_back({1'b1, 64'h01020304_05060708});
    send(8'h01, 8, 1'b0, 1'b0);
    check_pass("full");

    // Input-only frame reusing weights
    exp_q.push_back({1'b1, 64'h01020304_11121314});
    send(8'h11, 4, 1'b1, 1'b0);
    check_pass("inonly");

    // in_valid held high with 0xAA through a pass
    exp_q.push_back({1'b1, 64'h21222324_25262728});
    send(8'h21, 8, 1'b0, 1'b1);
    check_pass("hold");
    step();
    hif.in_valid = 1'b0;
    chk("hold_first_byte", 65'(weights[0]), 65'hAA);
    chk("hold_wv_cleared", 65'(weights_valid), 65'd0);
    chk("hold_busy", 65'(busy), 65'd1);
    exp_q.push_back({1'b1, 64'hAAB1B2B3_B4B5B6B7});
    send(8'hB1, 7, 1'b0, 1'b0);
    check_pass("hold_frame");

    // Abort after two weight bytes
    send(8'h31, 2, 1'b0, 1'b0);
    hif.abort = 1'b1;
    step();
    hif.abort = 1'b0;
    chk("abort_busy", 65'(busy), 65'd0);
    chk("abort_wv", 65'(weights_valid), 65'd0);
    chk("abort_keep", 65'({weights[0], weights[1]}), 65'h3132);
    // Abort in IDLE drops the coincident byte
    hif.abort    = 1'b1;
    hif.in_valid = 1'b1;
    hif.in_data  = 8'h99;
    step();
    hif.abort    = 1'b0;
    hif.in_valid = 1'b0;
    chk("idle_abort_busy", 65'(busy), 65'd0);
    chk("idle_abort_drop", 65'(weights[0]), 65'h31);
    exp_q.push_back({1'b1, 64'h41424344_45464748});
    send(8'h41, 8, 1'b0, 1'b0);
    check_pass("after_abort");

    // Abort during COMPUTE
    send(8'h51, 4, 1'b1, 1'b0);
    chk("cabort_en", 65'(en), 65'd1);
    step();
    chk("cabort_cc1", 65'(compute_cycles), 65'd1);
    hif.abort = 1'b1;
    step();
    hif.abort = 1'b0;
    chk("cabort_en_off", 65'(en), 65'd0);
    chk("cabort_cc_off", 65'(compute_cycles), 65'd0);
    chk("cabort_idle", 65'(busy), 65'd0);
    chk("cabort_ready", 65'(hif.in_ready), 65'd1);
    chk("cabort_operands", operands(), {1'b1, 64'h41424344_51525354});

    // rst at compute_cycles=3
    send(8'h61, 8, 1'b0, 1'b0);
    step();
    step();
    step();
    chk("rstmid_cc3", 65'(compute_cycles), 65'd3);
    rst = 1'b1;
    step();
    chk("rstmid_en", 65'(en), 65'd0);
    chk("rstmid_cc", 65'(compute_cycles), 65'd0);
    chk("rstmid_operands", operands(), 65'd0);
    chk("rstmid_busy", 65'(busy), 65'd0);
    chk("rstmid_ready_lo", 65'(hif.in_ready), 65'd0);
    rst = 1'b0;
    #1;
    chk("rstmid_ready_hi", 65'(hif.in_ready), 65'd1);

    // reuse_weights with no valid weights falls back to a full frame
    send(8'h71, 4, 1'b1, 1'b0);
    chk("noreuse_no_en", 65'(en), 65'd0);
    chk("noreuse_busy", 65'(busy), 65'd1);
    chk("noreuse_wv", 65'(weights_valid), 65'd1);
    exp_q.push_back({1'b1, 64'h71727374_75767778});
    send(8'h75, 4, 1'b0, 1'b0);
    check_pass("noreuse");

    chk("sb_drained", 65'(exp_q.size()), 65'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/mmu_loader.md
Name: mmu_loader

Overview:
- Upstream stage of the MMU feeder.
- Accepts a byte stream from the host, captures a 2x2 weight matrix and a 2x2 input matrix, then sequences the feeder by driving `en` and `compute_cycles` through one compute pass.
- Holds the operand registers stable while the pass runs, and back-pressures the host until the pass is finished.

Parameters:
- DATA_W, 8, width of each matrix element and of the host byte.
- LAST_CC, 5, final `compute_cycles` value of a pass; a pass is LAST_CC+1 cycles.
- CC_W, 3, width of `compute_cycles`.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  host byte strobe.
- in_data  in  DATA_W  host byte.
- in_ready  out  1  loader accepts a byte this cycle.
- reuse_weights  in  1  sampled on the first byte of a frame; selects an input-only frame.
- abort  in  1  cancels the current frame or pass.
- weights  out  DATA_W x [0:3]  unpacked array, weight matrix to the feeder.
- inputs  out  DATA_W x [0:3]  unpacked array, input matrix to the feeder.
- en  out  1  feeder enable.
- compute_cycles  out  CC_W  feeder step index.
- weights_valid  out  1  all four weight registers hold a complete set.
- busy  out  1  high in LOAD or COMPUTE.

Behaviour:
- One clock domain (clk); reset is synchronous and active-high (rst).
- Reset values:
  - state=IDLE, byte count=0, mode=full.
  - weights[*]=0, inputs[*]=0, weights_valid=0.
  - en=0, compute_cycles=0, busy=0.
- in_ready = (state != COMPUTE) && !rst, combinational. A byte is accepted when in_valid && in_ready.
- States: IDLE, LOAD, COMPUTE.
- Frame type is decided on the accepted byte taken with count==0:
  - reuse_weights=1 and weights_valid=1: input-only frame, 4 bytes, to inputs[0..3]. Weights are untouched.
  - Otherwise: full frame, 8 bytes. Bytes 0-3 go to weights[0..3] and bytes 4-7 go to inputs[0..3].
  - A full frame clears weights_valid on its byte 0 and sets it on its byte 3.
- Element order is row-major: element [0] is the first byte of its group.
- IDLE: an accepted byte is stored and count becomes 1. Next state is LOAD, or COMPUTE if it was also the last byte of the frame. With no byte, stay in IDLE.
- LOAD: each accepted byte is stored at count and count increments. Gaps in in_valid are allowed with no timeout. When the last byte is accepted, count goes to 0 and the next state is COMPUTE.
- COMPUTE timing, with the last byte accepted in cycle t:
  - en=1 and compute_cycles=0 in cycle t+1.
  - compute_cycles increments by 1 each cycle and reaches LAST_CC in cycle t+LAST_CC+1.
  - In the next cycle en=0, compute_cycles=0, state=IDLE and in_ready=1.
  - compute_cycles never wraps past LAST_CC.
- While in COMPUTE, in_valid is ignored (in_ready=0) and weights/inputs are frozen.
- busy = (state != IDLE), registered with state.
- abort (priority over byte acceptance, below rst):
  - In LOAD: go to IDLE and count=0. If the frame was full and fewer than 4 weight bytes had been accepted, weights_valid=0; otherwise it is kept. Partially written data registers keep their values.
  - In COMPUTE: en=0, compute_cycles=0, go to IDLE next cycle.
  - In IDLE: no effect. A byte presented in the same cycle as abort is dropped.
- rst mid-operation: everything returns to reset values in the next cycle, including weights_valid=0.
- A new frame may begin in the first IDLE cycle after a pass; there is no dead cycle.

Decomposition:
- Shared package tpu_pkg:
  - loader_state_t enum {IDLE, LOAD, COMPUTE}.
  - N_ELEM=4, FULL_FRAME_BYTES=8, INPUT_FRAME_BYTES=4, LAST_CC=5.
  - The feeder uses the same LAST_CC constant for its final step.
- No sub-module. Byte counter, operand registers and pass counter stay in one module of roughly 150-200 lines.

Test Plan:
- Full frame: bytes 0x01..0x08 sent back-to-back from IDLE → weights={1,2,3,4}, inputs={5,6,7,8}, weights_valid=1. en is high for exactly 6 cycles starting the cycle after byte 8, with compute_cycles 0,1,2,3,4,5. in_ready returns to 1 the cycle after cc=5.
- Input-only frame: after the full frame, reuse_weights=1 with bytes 0x11..0x14 → inputs={0x11..0x14}, weights unchanged {1,2,3,4}, pass starts after the 4th byte.
- reuse_weights=1 right after reset (weights_valid=0) → frame treated as full, 8 bytes required before en rises.
- in_valid held high with 0xAA throughout a pass → in_ready=0, no register changes. The first byte accepted is the one in the cycle after cc=5.
- abort after 2 weight bytes → IDLE, weights_valid=0, count=0. The next 8 bytes form a full frame normally.
- rst asserted at compute_cycles=3 → next cycle en=0, cc=0, weights/inputs=0, weights_valid=0, in_ready=1 once rst is low.
